// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_feeder
// Brief    : Parallel-to-serial converter with valid/ready input handshake and
//            a one-word holding buffer for gap-free streaming. Emits one bit
//            per clock on ser_out, qualified by ser_valid, with word_start /
//            word_last framing strobes. IDLE_BIT is driven when idle.
//            Optional macro SERIAL_FEEDER_PARITY_EN appends an even-parity bit
//            after each word's data bits.
// Revision : 1.0 - initial release
// ============================================================================
module serial_bit_feeder #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             msb_first,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_start,
    output logic             word_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

`ifdef SERIAL_FEEDER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sr, w_sr_nxt;
    logic             r_sr_msb, w_sr_msb_nxt;
    logic [WIDTH-1:0] r_hb, w_hb_nxt;
    logic             r_hb_msb, w_hb_msb_nxt;
    logic             r_hb_full, w_hb_full_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_ser_out, w_ser_out_nxt;
    logic             r_ser_valid, w_ser_valid_nxt;
    logic             r_word_start, w_word_start_nxt;
    logic             r_word_last, w_word_last_nxt;

    logic             w_xfer;
    logic             w_last_on;
    logic             w_need_load;
    logic [IW-1:0]    w_idx;
    logic [WIDTH-1:0] w_ld_word;
    logic             w_ld_msb;
    logic             w_do_load;

    assign w_xfer = din_valid && !r_hb_full;

    // The final bit of the current word is on ser_out, so the next edge
    // either starts the following word or returns to idle.
`ifdef SERIAL_FEEDER_PARITY_EN
    assign w_last_on = (r_state == ST_PARITY);
`else
    assign w_last_on = (r_state == ST_SHIFT) && (r_cnt == CW'(WIDTH));
`endif

    assign w_need_load = (r_state == ST_IDLE) || w_last_on;

    // r_cnt counts bits already emitted; it is the sequence position of the
    // next data bit.
    assign w_idx = r_sr_msb ? (IW'(WIDTH - 1) - IW'(r_cnt)) : IW'(r_cnt);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_sr_nxt         = r_sr;
        w_sr_msb_nxt     = r_sr_msb;
        w_hb_nxt         = r_hb;
        w_hb_msb_nxt     = r_hb_msb;
        w_hb_full_nxt    = r_hb_full;
        w_cnt_nxt        = r_cnt;
        w_ser_out_nxt    = IDLE_BIT;
        w_ser_valid_nxt  = 1'b0;
        w_word_start_nxt = 1'b0;
        w_word_last_nxt  = 1'b0;
        w_ld_word        = '0;
        w_ld_msb         = 1'b0;
        w_do_load        = 1'b0;

        if (w_need_load) begin
            // Holding buffer has priority; when it is full din_ready is low,
            // so a direct load from din cannot collide with it.
            if (r_hb_full) begin
                w_ld_word     = r_hb;
                w_ld_msb      = r_hb_msb;
                w_do_load     = 1'b1;
                w_hb_full_nxt = 1'b0;
            end else if (w_xfer) begin
                w_ld_word = din;
                w_ld_msb  = msb_first;
                w_do_load = 1'b1;
            end

            if (w_do_load) begin
                // First bit goes out on the load edge itself, keeping
                // word-to-word transitions gap-free.
                w_state_nxt      = ST_SHIFT;
                w_sr_nxt         = w_ld_word;
                w_sr_msb_nxt     = w_ld_msb;
                w_cnt_nxt        = CW'(1);
                w_ser_out_nxt    = w_ld_msb ? w_ld_word[WIDTH-1] : w_ld_word[0];
                w_ser_valid_nxt  = 1'b1;
                w_word_start_nxt = 1'b1;
            end else begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        end else begin
            if (w_xfer) begin
                w_hb_nxt      = din;
                w_hb_msb_nxt  = msb_first;
                w_hb_full_nxt = 1'b1;
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            if (r_cnt == CW'(WIDTH)) begin
                w_state_nxt     = ST_PARITY;
                w_ser_out_nxt   = ^r_sr;
                w_ser_valid_nxt = 1'b1;
                w_word_last_nxt = 1'b1;
            end else begin
                w_ser_out_nxt   = r_sr[w_idx];
                w_ser_valid_nxt = 1'b1;
                w_cnt_nxt       = r_cnt + CW'(1);
            end
`else
            w_ser_out_nxt   = r_sr[w_idx];
            w_ser_valid_nxt = 1'b1;
            w_word_last_nxt = (r_cnt == CW'(WIDTH - 1));
            w_cnt_nxt       = r_cnt + CW'(1);
`endif
        end
    end

    // Storage and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr         <= '0;
            r_sr_msb     <= 1'b0;
            r_hb         <= '0;
            r_hb_msb     <= 1'b0;
            r_hb_full    <= 1'b0;
            r_cnt        <= '0;
            r_ser_out    <= IDLE_BIT;
            r_ser_valid  <= 1'b0;
            r_word_start <= 1'b0;
            r_word_last  <= 1'b0;
        end else begin
            r_sr         <= w_sr_nxt;
            r_sr_msb     <= w_sr_msb_nxt;
            r_hb         <= w_hb_nxt;
            r_hb_msb     <= w_hb_msb_nxt;
            r_hb_full    <= w_hb_full_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ser_out    <= w_ser_out_nxt;
            r_ser_valid  <= w_ser_valid_nxt;
            r_word_start <= w_word_start_nxt;
            r_word_last  <= w_word_last_nxt;
        end
    end

    assign din_ready  = ~r_hb_full;
    assign ser_out    = r_ser_out;
    assign ser_valid  = r_ser_valid;
    assign word_start = r_word_start;
    assign word_last  = r_word_last;
    assign busy       = (r_state != ST_IDLE) || r_hb_full;

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_bit_feeder
// Brief    : Directed self-checking bench for serial_bit_feeder (WIDTH=8).
//            Follows SERIAL_FEEDER_PARITY_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_bit_feeder;

`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       msb_first = 1'b1;
    logic       ser_out;
    logic       ser_valid;
    logic       word_start;
    logic       word_last;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    serial_bit_feeder #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .msb_first  (msb_first),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .word_start (word_start),
        .word_last  (word_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Downstream 1010 detector (overlapping), counting hits on valid bits.
    logic [3:0] det_win = 4'h0;
    int         det_cnt = 0;
    logic       det_clr = 1'b0;
    always @(posedge clk) begin
        if (det_clr) begin
            det_win <= 4'h0;
            det_cnt <= 0;
        end else if (ser_valid) begin
            det_win <= {det_win[2:0], ser_out};
            if ({det_win[2:0], ser_out} == 4'b1010)
                det_cnt <= det_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one word for a single accept edge (block must be ready).
    task automatic send_one(input logic [7:0] data, input logic msb);
        @(posedge clk); #1;
        din       = data;
        msb_first = msb;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    // seq holds the 9-bit emission order (data bits then parity), MSB first.
    task automatic check_word(input string tag, input logic [8:0] seq);
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            check({tag, "_bit"},   32'(ser_out),    32'(seq[8-i]));
            check({tag, "_valid"}, 32'(ser_valid),  32'd1);
            check({tag, "_start"}, 32'(word_start), 32'(i == 0));
            check({tag, "_last"},  32'(word_last),  32'(i == NB - 1));
        end
        @(negedge clk);
        check({tag, "_idle_valid"}, 32'(ser_valid), 32'd0);
        check({tag, "_idle_out"},   32'(ser_out),   32'd0);
        check({tag, "_idle_busy"},  32'(busy),      32'd0);
    endtask

    initial begin : main
        logic [7:0]  words [3];
        int          idx;
        int          vcnt, first_c, last_c, nstart, saw_bp;
        int          spos [3];
        logic        acc;
        logic [31:0] stream;
        int          post_valid;

        // Reset state
        @(negedge clk);
        check("rst_ser_out",    32'(ser_out),    32'd0);
        check("rst_ser_valid",  32'(ser_valid),  32'd0);
        check("rst_word_start", 32'(word_start), 32'd0);
        check("rst_word_last",  32'(word_last),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_din_ready",  32'(din_ready),  32'd1);
        @(posedge clk); #3;
        rst = 1'b0;

        // Single word, MSB first: A5 -> 1010_0101, parity 0
        send_one(8'hA5, 1'b1);
        check_word("a5_msb", 9'b1010_0101_0);

        // LSB first: 0A -> 0101_0000, parity 0; one 1010 hit downstream
        det_clr = 1'b1;
        @(posedge clk); #1;
        det_clr = 1'b0;
        send_one(8'h0A, 1'b0);
        check_word("0a_lsb", 9'b0101_0000_0);
        check("det_1010_count", 32'(det_cnt), 32'd1);

        // 07 MSB first: 0000_0111, parity 1
        send_one(8'h07, 1'b1);
        check_word("07_msb", 9'b0000_0111_1);

        // Back-to-back streaming with backpressure (din garbled while not ready)
        words  = '{8'h0A, 8'hFF, 8'h3C};
        idx    = 0;
        vcnt   = 0; first_c = -1; last_c = -1; nstart = 0; saw_bp = 0;
        spos   = '{0, 0, 0};
        stream = '0;
        @(posedge clk); #1;
        din = words[0]; msb_first = 1'b1; din_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ser_valid) begin
                vcnt++;
                if (first_c < 0) first_c = c;
                last_c = c;
                stream = {stream[30:0], ser_out};
            end
            if (word_start) begin
                if (nstart < 3) spos[nstart] = c;
                nstart++;
            end
            acc = din_valid && din_ready;
            if (din_valid && !din_ready) saw_bp = 1;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx >= 3) din_valid = 1'b0;
            end
            if (din_valid) din = din_ready ? words[idx] : 8'hEE;
        end
        check("b2b_valid_cycles", 32'(vcnt), 32'(3 * NB));
        check("b2b_contiguous",   32'(last_c - first_c + 1), 32'(3 * NB));
        check("b2b_starts",       32'(nstart), 32'd3);
        check("b2b_gap_1",        32'(spos[1] - spos[0]), 32'(NB));
        check("b2b_gap_2",        32'(spos[2] - spos[1]), 32'(NB));
        check("b2b_backpressure", 32'(saw_bp), 32'd1);
`ifdef SERIAL_FEEDER_PARITY_EN
        check("b2b_stream", stream & 32'h07FF_FFFF, {5'd0, 8'h0A, 1'b0, 8'hFF, 1'b0, 8'h3C, 1'b0});
`else
        check("b2b_stream", stream & 32'h00FF_FFFF, 32'h000A_FF3C);
`endif
        check("b2b_end_busy", 32'(busy), 32'd0);

        // Reset mid-word: A5 shifting, 11 in the holding buffer
        @(posedge clk); #1;
        din = 8'hA5; msb_first = 1'b1; din_valid = 1'b1;
        @(posedge clk); #1;
        din = 8'h11;
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(negedge clk);
        check("mid_hb_full_ready", 32'(din_ready), 32'd0);
        check("mid_busy",          32'(busy),      32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_bit3", 32'(ser_out), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(ser_valid),  32'd0);
        check("mid_rst_out",   32'(ser_out),    32'd0);
        check("mid_rst_start", 32'(word_start), 32'd0);
        check("mid_rst_last",  32'(word_last),  32'd0);
        check("mid_rst_busy",  32'(busy),       32'd0);
        check("mid_rst_ready", 32'(din_ready),  32'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        post_valid = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ser_valid) post_valid++;
        end
        check("post_rst_emitted", 32'(post_valid), 32'd0);
        check("post_rst_ready",   32'(din_ready),  32'd1);
        check("post_rst_busy",    32'(busy),       32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
